// File: rtl/stream_deframer_pkg.sv
// Shared constants for the stream deframer: FSM state codes, default sync marker,
// counter widths and a saturating increment helper.
package stream_deframer_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam int LEN_W = 8;
    localparam int PKT_W = 16;
    localparam int ERR_W = 8;
    localparam int CH_W  = 3;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_EMIT    = 3'd4;

    function automatic logic [ERR_W-1:0] satInc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_deframer_if.sv
// Byte-input / sample-output bundle of the stream deframer.
// The slave modport is the deframer's view; master is the environment's view.
interface stream_deframer_if #(
    parameter int NUM_CH = 4,
    parameter int SW     = 8
);
    logic [7:0]        rx_data_si;
    logic              rx_valid_si;
    logic              rx_ready_si;
    logic [SW-1:0]     out_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;

    modport master (
        output rx_data_si, rx_valid_si, out_ready,
        input  rx_ready_si, out_data, out_valid
    );

    modport slave (
        input  rx_data_si, rx_valid_si, out_ready,
        output rx_ready_si, out_data, out_valid
    );
endinterface

// File: rtl/stream_deframer_byte_packer.sv
// Assembles SAMPLE_BYTES bytes, MSB first, into one sample word.
// o_done marks the shift that completes a sample.
module stream_deframer_byte_packer #(
    parameter int SAMPLE_BYTES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_shift,
    input  logic [7:0]                  i_byte,
    output logic [8*SAMPLE_BYTES-1:0]   o_data,
    output logic                        o_done
);
    localparam int SW = 8 * SAMPLE_BYTES;

    logic [SW-1:0] r_data;
    logic [1:0]    r_count;
    logic          w_last;

    assign w_last = (r_count == 2'(SAMPLE_BYTES - 1));
    assign o_done = i_shift && w_last;
    assign o_data = r_data;

    // Clearing only rewinds the byte position; stale data is harmless because
    // a new sample fully overwrites it before it is ever presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_shift) begin
            r_data  <= (r_data << 8) | SW'(i_byte);
            r_count <= w_last ? 2'd0 : r_count + 2'd1;
        end
    end

endmodule

// File: rtl/stream_deframer.sv
// Splits a sync-marked byte stream into per-channel samples, with an idle
// timeout inside packets and good/bad packet counters.
module stream_deframer
    import stream_deframer_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter int         SAMPLE_BYTES = 1,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CLKS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_deframer_if.slave      bus,
    output logic [PKT_W-1:0]      pkt_count,
    output logic [ERR_W-1:0]      err_count,
    output logic                  busy
);
    localparam int SW = 8 * SAMPLE_BYTES;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [2:0]        r_state;
    logic [CH_W-1:0]   r_ch;
    logic              r_drop;
    logic [LEN_W-1:0]  r_samples;
    logic [TW-1:0]     r_timer;
    logic [PKT_W-1:0]  r_pkt;
    logic [ERR_W-1:0]  r_err;

    logic              w_accept;
    logic              w_timing;
    logic              w_timeout;
    logic              w_shift;
    logic              w_clear;
    logic              w_done;
    logic              w_emitFire;
    logic [SW-1:0]     w_data;
    logic [NUM_CH-1:0] w_valid;

    // Ready is gated by rst so nothing is offered while reset is held.
    assign bus.rx_ready_si = !rst && (r_state != ST_EMIT);
    assign w_accept  = bus.rx_valid_si && bus.rx_ready_si;
    assign w_timing  = (r_state == ST_HDR) || (r_state == ST_LEN) || (r_state == ST_PAYLOAD);
    assign w_timeout = w_timing && !w_accept && (r_timer == TW'(TIMEOUT_CLKS - 1));
    assign w_shift   = (r_state == ST_PAYLOAD) && w_accept;
    assign w_clear   = w_timeout || ((r_state == ST_LEN) && w_accept);

    stream_deframer_byte_packer #(
        .SAMPLE_BYTES (SAMPLE_BYTES)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_byte  (bus.rx_data_si),
        .o_data  (w_data),
        .o_done  (w_done)
    );

    always_comb begin
        w_valid = '0;
        if (r_state == ST_EMIT) begin
            for (int i = 0; i < NUM_CH; i++) begin
                w_valid[i] = (r_ch == CH_W'(i));
            end
        end
    end

    assign w_emitFire    = |(w_valid & bus.out_ready);
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign pkt_count     = r_pkt;
    assign err_count     = r_err;
    assign busy          = (r_state != ST_HUNT);

    // Idle timer only runs while a packet is being received from the host,
    // so downstream backpressure in EMIT can never cause a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!w_timing || w_accept || w_timeout) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_HUNT;
            r_ch      <= '0;
            r_drop    <= 1'b0;
            r_samples <= '0;
            r_pkt     <= '0;
            r_err     <= '0;
        end else if (w_timeout) begin
            r_state <= ST_HUNT;
            r_drop  <= 1'b0;
            r_err   <= satInc(r_err);
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_accept && (bus.rx_data_si == SYNC_BYTE)) r_state <= ST_HDR;
                end
                ST_HDR: begin
                    if (w_accept) begin
                        r_ch    <= bus.rx_data_si[2:0];
                        r_drop  <= (int'(bus.rx_data_si[2:0]) >= NUM_CH);
                        r_state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_accept) begin
                        if (bus.rx_data_si == 8'd0) begin
                            r_err   <= satInc(r_err);
                            r_drop  <= 1'b0;
                            r_state <= ST_HUNT;
                        end else begin
                            r_samples <= bus.rx_data_si;
                            r_state   <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_done) begin
                        r_samples <= r_samples - 1'b1;
                        // A dropped packet is swallowed whole and counted once at its end.
                        if (r_drop) begin
                            if (r_samples == LEN_W'(1)) begin
                                r_err   <= satInc(r_err);
                                r_drop  <= 1'b0;
                                r_state <= ST_HUNT;
                            end
                        end else begin
                            r_state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_emitFire) begin
                        if (r_samples == '0) begin
                            r_pkt   <= r_pkt + 1'b1;
                            r_state <= ST_HUNT;
                        end else begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_deframer.sv
// Bench for stream_deframer (4 channels, 2-byte samples, 16-clock timeout):
// directed packets plus randomized traffic checked against a packet-level model.
module tb_stream_deframer;

    localparam int NUM_CH       = 4;
    localparam int SAMPLE_BYTES = 2;
    localparam int TIMEOUT_CLKS = 16;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
    } expSample_t;

    logic        clk;
    logic        rst;
    logic [15:0] pktCount;
    logic [7:0]  errCount;
    logic        busy;
    logic [3:0]  manualReady;
    logic [3:0]  rndReady;
    logic        randReady;

    int          vectors = 0;
    int          miscompares = 0;
    expSample_t  expQ[$];
    logic [15:0] pay[$];
    logic [15:0] expPkt;
    logic [7:0]  expErr;

    stream_deframer_if #(.NUM_CH(NUM_CH), .SW(8 * SAMPLE_BYTES)) bus ();

    assign bus.out_ready = randReady ? rndReady : manualReady;

    stream_deframer #(
        .NUM_CH       (NUM_CH),
        .SAMPLE_BYTES (SAMPLE_BYTES),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pkt_count (pktCount),
        .err_count (errCount),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s check did not hold", tag);
        end
    endtask

    function automatic logic [7:0] satErr(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Packet-level expectation: bad length or unknown channel is one error,
    // otherwise every sample appears on its channel and the packet counts once.
    function automatic void modelPacket(input logic [7:0] hdr, input logic [7:0] len);
        if (len == 8'd0 || int'(hdr[2:0]) >= NUM_CH) begin
            expErr = satErr(expErr);
        end else begin
            foreach (pay[i]) expQ.push_back('{ch: hdr[2:0], data: pay[i]});
            expPkt = expPkt + 16'd1;
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        bus.rx_data_si  = b;
        bus.rx_valid_si = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready_si && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.rx_ready_si) checkOutput("rx_ready_wait", {31'd0, bus.rx_ready_si}, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid_si = 1'b0;
    endtask

    task automatic idleGap(input int gapMax);
        repeat ($urandom_range(0, gapMax)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendPacket(input logic [7:0] hdr, input int gapMax);
        logic [7:0] len;
        len = 8'(pay.size());
        modelPacket(hdr, len);
        applyStimulus(8'hA5);
        idleGap(gapMax);
        applyStimulus(hdr);
        idleGap(gapMax);
        applyStimulus(len);
        foreach (pay[i]) begin
            idleGap(gapMax);
            applyStimulus(pay[i][15:8]);
            idleGap(gapMax);
            applyStimulus(pay[i][7:0]);
        end
    endtask

    task automatic checkCounts(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) checkOutput({tag, "_drain"}, expQ.size(), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pkt"}, {16'd0, pktCount}, {16'd0, expPkt});
        checkOutput({tag, "_err"}, {24'd0, errCount}, {24'd0, expErr});
    endtask

    initial begin
        rst             = 1'b1;
        bus.rx_valid_si = 1'b0;
        bus.rx_data_si  = 8'h00;
        manualReady     = 4'hF;
        rndReady        = 4'hF;
        randReady       = 1'b0;
        expPkt          = 16'd0;
        expErr          = 8'd0;

        // Output monitor and random backpressure run alongside the directed steps.
        fork
            forever begin
                @(negedge clk);
                if (!rst && (bus.out_valid & bus.out_ready) != 4'd0) begin
                    expSample_t e;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_sample", {28'd0, bus.out_valid}, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sample_valid", {28'd0, bus.out_valid}, 32'd1 << e.ch);
                        checkOutput("sample_data", {16'd0, bus.out_data}, {16'd0, e.data});
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                rndReady = 4'($urandom) | 4'($urandom);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rx_ready", {31'd0, bus.rx_ready_si}, 32'd0);
        checkOutput("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        checkOutput("rst_pkt", {16'd0, pktCount}, 32'd0);
        checkOutput("rst_err", {24'd0, errCount}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        // Basic packet, sync byte offered in the same cycle reset is released.
        pay = '{16'h1234, 16'h5678};
        modelPacket(8'h02, 8'd2);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.rx_data_si  = 8'hA5;
        bus.rx_valid_si = 1'b1;
        #1;
        checkOutput("first_ready", {31'd0, bus.rx_ready_si}, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid_si = 1'b0;
        checkOutput("first_accept_busy", {31'd0, busy}, 32'd1);
        applyStimulus(8'h02);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        checkCounts("basic");

        // Channel 2 stalled for 10 clocks on the first sample.
        pay = '{16'h1234, 16'h5678};
        modelPacket(8'h02, 8'd2);
        manualReady = 4'b1011;
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        repeat (10) begin
            @(negedge clk);
            checkOutput("stall_ready", {31'd0, bus.rx_ready_si}, 32'd0);
            checkOutput("stall_data", {16'd0, bus.out_data}, 32'h1234);
            checkOutput("stall_valid", {28'd0, bus.out_valid}, 32'b0100);
        end
        checkOutput("stall_err", {24'd0, errCount}, {24'd0, expErr});
        @(posedge clk);
        #1;
        manualReady = 4'hF;
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        checkCounts("stall");

        // Unknown channel is dropped; the next packet is unaffected.
        pay = '{16'hAABB};
        sendPacket(8'h07, 0);
        pay = '{16'hCDEF};
        sendPacket(8'h00, 0);
        checkCounts("drop");

        // Garbage before sync is ignored; zero length is an error.
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h11);
        pay.delete();
        sendPacket(8'h01, 0);
        checkCounts("zero_len");
        checkOutput("zero_len_busy", {31'd0, busy}, 32'd0);

        // Stall mid-sample until the idle timeout fires on the 16th idle clock.
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        applyStimulus(8'h12);
        repeat (TIMEOUT_CLKS - 1) begin
            @(posedge clk);
            #1;
        end
        checkOutput("timeout_early_err", {24'd0, errCount}, {24'd0, expErr});
        checkOutput("timeout_early_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        expErr = satErr(expErr);
        checkOutput("timeout_err", {24'd0, errCount}, {24'd0, expErr});
        checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        pay = '{16'h9ABC};
        sendPacket(8'h03, 0);
        checkCounts("after_timeout");

        // Randomized packets, garbage and backpressure.
        randReady = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int nGarb;
            int nSamp;
            nGarb = $urandom_range(0, 2);
            for (int g = 0; g < nGarb; g++) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h5A;
                applyStimulus(gb);
            end
            pay.delete();
            nSamp = $urandom_range(0, 4);
            for (int s = 0; s < nSamp; s++) pay.push_back(16'($urandom));
            sendPacket(8'($urandom), 3);
            checkCounts("random");
        end
        randReady   = 1'b0;
        manualReady = 4'hF;

        // Reset in the middle of the second sample of a packet.
        pay = '{16'h3344, 16'h5566};
        expQ.push_back('{ch: 3'd1, data: 16'h3344});
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'h55);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_rx_ready", {31'd0, bus.rx_ready_si}, 32'd0);
        checkOutput("midrst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        checkOutput("midrst_out_data", {16'd0, bus.out_data}, 32'd0);
        checkOutput("midrst_pkt", {16'd0, pktCount}, 32'd0);
        checkOutput("midrst_err", {24'd0, errCount}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        expQ.delete();
        expPkt = 16'd0;
        expErr = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pay = '{16'h0F0F};
        sendPacket(8'h02, 0);
        checkCounts("post_reset");

        // Error counter saturation.
        pay.delete();
        for (int k = 0; k < 300; k++) sendPacket(8'h01, 0);
        checkCounts("saturate");
        checkOutput("saturate_ff", {24'd0, errCount}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_deframer.md
STREAM_DEFRAMER -- requirements
Module: stream_deframer

Interface
REQ-001 Parameter NUM_CH, default 4, number of output channels (1..8).
REQ-002 Parameter SAMPLE_BYTES, default 1, bytes per sample (1..3); SW = 8*SAMPLE_BYTES.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, packet start marker.
REQ-004 Parameter TIMEOUT_CLKS, default 1024, max idle clocks between bytes inside a packet.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 rx_data_si  in  8  byte from FT245 simple interface.
REQ-008 rx_valid_si  in  1  byte available.
REQ-009 rx_ready_si  out  1  block accepts byte; transfer when valid and ready both high.
REQ-010 out_data  out  SW  assembled sample, shared by all channels.
REQ-011 out_valid  out  NUM_CH  one-hot, sample valid for that channel.
REQ-012 out_ready  in  NUM_CH  per-channel downstream ready.
REQ-013 pkt_count  out  16  completed good packets, wrapping.
REQ-014 err_count  out  8  framing errors, saturating at 255.
REQ-015 busy  out  1  high whenever state is not HUNT.

Function
REQ-016 Packet format SHALL be: SYNC_BYTE, HDR (bits[2:0] channel id), LEN (samples, 1..255), then LEN*SAMPLE_BYTES payload bytes, MSB of each sample first.
REQ-017 FSM states SHALL be HUNT, HDR, LEN, PAYLOAD, EMIT.
REQ-018 HUNT: bytes other than SYNC_BYTE SHALL be consumed silently; SYNC_BYTE -> HDR.
REQ-019 HDR: store channel id -> LEN; id >= NUM_CH sets drop flag for the packet.
REQ-020 LEN: value 0 -> err_count+1, HUNT; else load sample counter -> PAYLOAD.
REQ-021 PAYLOAD: shift bytes into SW register; on SAMPLE_BYTES-th byte -> EMIT, or when drop flag set, sample discarded and stay (count still decremented).
REQ-022 EMIT: out_valid[ch] high the cycle after last sample byte accepted; out_data stable until out_valid[ch] and out_ready[ch] both high.
REQ-023 On EMIT handshake: counter=0 -> pkt_count+1, HUNT; else PAYLOAD.
REQ-024 Dropped packet end SHALL increment err_count once, not pkt_count.
REQ-025 rx_ready_si SHALL be high in HUNT, HDR, LEN, PAYLOAD and low in EMIT; no byte accepted in EMIT.
REQ-026 Idle timer SHALL count clocks without accepted byte in HDR, LEN, PAYLOAD; reaching TIMEOUT_CLKS -> err_count+1, partial sample discarded, HUNT.
REQ-027 Timer SHALL NOT run in HUNT or EMIT (downstream backpressure is never an error).
REQ-028 SYNC_BYTE value inside HDR/LEN/PAYLOAD SHALL be treated as data (no resync).
REQ-029 err_count saturates at 8'hFF; pkt_count wraps 16'hFFFF -> 0.
REQ-030 out_valid SHALL never have more than one bit set.

Reset
REQ-031 While rst high: state HUNT, rx_ready_si 0, out_valid 0, out_data 0, pkt_count 0, err_count 0, busy 0, timer 0, drop flag 0.
REQ-032 rst mid-packet SHALL abort immediately; a pending sample is lost and not counted.
REQ-033 First byte accepted on first clock edge after rst deasserts (rx_ready_si high).

Structure
REQ-034 State encoding, SYNC_BYTE default and counter widths SHALL live in the shared module_params include.
REQ-035 Sub-module byte_packer (SAMPLE_BYTES-deep shift register with byte counter and done flag) SHALL hold assembly logic; FSM, timer and counters stay in stream_deframer.
REQ-036 No other hierarchy; target 150-300 RTL lines.

Verification (NUM_CH=4, SAMPLE_BYTES=2, TIMEOUT_CLKS=16)
REQ-037 Bytes A5 02 02 12 34 56 78, out_ready all 1 -> out_valid=4'b0100 with 16'h1234 then 16'h5678; pkt_count=1, err_count=0.
REQ-038 Same packet, out_ready[2] held 0 for 10 clocks on first sample -> rx_ready_si 0, out_data 16'h1234 held, no timeout, then normal completion.
REQ-039 A5 07 01 AA BB -> no out_valid, err_count=1, pkt_count=0; following A5 00 01 CD EF -> out_valid=4'b0001, 16'hCDEF.
REQ-040 A5 01 00 -> err_count=1, state HUNT; garbage 00 FF 11 before A5 ignored.
REQ-041 A5 01 01 12 then 20 idle clocks -> err_count=1 at clock 16, busy 0, no out_valid.
REQ-042 rst asserted during PAYLOAD -> all outputs zero asynchronously; 300 bad-length packets -> err_count=255.
